sump_cmd_decoder: RTL and testbench

//  Assembles SUMP-protocol commands from the UART receiver byte stream and presents them to the

---
 rtl/sump_cmd_if.sv | 23 ++
 rtl/sump_cmd_decoder.sv | 109 ++++++++++
 tb/tb_sump_cmd_decoder.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sump_cmd_if.sv
// Byte-stream and decoded-command bundle between the UART receiver, the SUMP
// command decoder and the capture controller.
interface sump_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        cmd_dropped;

  // Byte source side: the UART receiver, or a bench standing in for it.
  modport master (
    output rx_data, rx_valid, rx_error,
    input  opcode, command, cmd_recv_rx, cmd_dropped
  );

  // Decoder side.
  modport slave (
    input  rx_data, rx_valid, rx_error,
    output opcode, command, cmd_recv_rx, cmd_dropped
  );
endinterface

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: frames 1-byte short and 5-byte long commands from the
// UART byte stream, with inter-byte timeout and framing-error abort.
module sump_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clock,
  input  logic         ext_reset_n,
  sump_cmd_if.slave    bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    WAIT_OP,
    WAIT_ARG
  } state_t;

  state_t          state_q;
  logic [7:0]      pending_q;
  logic [31:0]     arg_q;
  logic [1:0]      idx_q;
  logic [TO_W-1:0] timer_q;
  logic [7:0]      opcode_q;
  logic [31:0]     command_q;
  logic            recv_q;
  logic            drop_q;

  logic            byte_ok;
  logic [31:0]     arg_next;

  // A framing error poisons the byte even when rx_valid is also high.
  assign byte_ok  = bus.rx_valid && !bus.rx_error;
  // Little-endian: each new byte enters at the top, so arg byte 0 ends in [7:0].
  assign arg_next = {bus.rx_data, arg_q[31:8]};

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      // NOTE: every register, the argument shift register included, is reset so
      // that a reset mid-command leaves no stale partial argument behind.
      state_q   <= WAIT_OP;
      pending_q <= 8'h00;
      arg_q     <= 32'h0;
      idx_q     <= 2'd0;
      timer_q   <= '0;
      opcode_q  <= 8'h00;
      command_q <= 32'h0;
      recv_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make both strobes single-cycle pulses; any
      // later assignment in this block overrides them for this cycle only.
      recv_q <= 1'b0;
      drop_q <= 1'b0;

      case (state_q)
        WAIT_OP: begin
          if (byte_ok) begin
            if (!bus.rx_data[7]) begin
              opcode_q  <= bus.rx_data;
              command_q <= 32'h0;
              recv_q    <= 1'b1;
            end else begin
              pending_q <= bus.rx_data;
              arg_q     <= 32'h0;
              idx_q     <= 2'd0;
              timer_q   <= '0;
              state_q   <= WAIT_ARG;
            end
          end
        end

        WAIT_ARG: begin
          if (bus.rx_error) begin
            drop_q  <= 1'b1;
            state_q <= WAIT_OP;
          end else if (bus.rx_valid) begin
            // A byte arriving on the expiry cycle lands here and wins.
            arg_q   <= arg_next;
            idx_q   <= idx_q + 2'd1;
            timer_q <= '0;
            if (idx_q == 2'd3) begin
              opcode_q  <= pending_q;
              command_q <= arg_next;
              recv_q    <= 1'b1;
              state_q   <= WAIT_OP;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == TIMER_LAST) begin
              drop_q  <= 1'b1;
              state_q <= WAIT_OP;
            end
          end
        end
      endcase
    end
  end

  assign bus.opcode      = opcode_q;
  assign bus.command     = command_q;
  assign bus.cmd_recv_rx = recv_q;
  assign bus.cmd_dropped = drop_q;

  a_pulses_exclusive: assert property (
    @(posedge clock) disable iff (!ext_reset_n) !(recv_q && drop_q)
  );

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios plus random byte streams,
// all checked against a queue-based model of SUMP command framing.
module tb_sump_cmd_decoder;
  localparam int TMO = 20;

  logic clock = 1'b0;
  logic ext_reset_n = 1'b0;

  sump_cmd_if bus ();

  sump_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .bus         (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: a command is an opcode plus a list of collected args.
  bit          m_collect;
  logic [7:0]  m_pend;
  logic [7:0]  m_args[$];
  int          m_idle;
  logic [7:0]  exp_op;
  logic [31:0] exp_cmd;
  logic        exp_recv;
  logic        exp_drop;

  task automatic model_reset();
    m_collect = 0;
    m_pend    = 8'h00;
    m_args.delete();
    m_idle    = 0;
    exp_op    = 8'h00;
    exp_cmd   = 32'h0;
    exp_recv  = 1'b0;
    exp_drop  = 1'b0;
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d, input logic e);
    exp_recv = 1'b0;
    exp_drop = 1'b0;
    if (e) begin
      if (m_collect) begin
        exp_drop  = 1'b1;
        m_collect = 0;
      end
    end else if (v) begin
      if (!m_collect) begin
        if (d < 8'h80) begin
          exp_op   = d;
          exp_cmd  = 32'h0;
          exp_recv = 1'b1;
        end else begin
          m_collect = 1;
          m_pend    = d;
          m_args.delete();
          m_idle    = 0;
        end
      end else begin
        m_args.push_back(d);
        m_idle = 0;
        if (m_args.size() == 4) begin
          exp_op    = m_pend;
          exp_cmd   = m_args[0] + (m_args[1] * 256) + (m_args[2] * 65536)
                    + (m_args[3] * 32'd16777216);
          exp_recv  = 1'b1;
          m_collect = 0;
        end
      end
    end else if (m_collect) begin
      m_idle++;
      if (m_idle == TMO) begin
        exp_drop  = 1'b1;
        m_collect = 0;
      end
    end
  endtask

  // Drive one cycle of input, let the edge pass, then advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic e);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rx_error = e;
    @(posedge clock);
    #1;
    model_cycle(v, d, e);
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic test_reset();
    ext_reset_n  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({bus.opcode, bus.command, bus.cmd_recv_rx, bus.cmd_dropped} !== 42'h0) begin
      bad++;
      $display("FAIL reset_outputs: got op=%h cmd=%h recv=%b drop=%b want all zero",
               bus.opcode, bus.command, bus.cmd_recv_rx, bus.cmd_dropped);
    end
    ext_reset_n = 1'b1;
  endtask

  task automatic test_short();
    step(1'b1, 8'h02, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h02 || bus.command !== 32'h0) begin
      bad++;
      $display("FAIL short_cmd: got recv=%b op=%h cmd=%h want 1 02 00000000",
               bus.cmd_recv_rx, bus.opcode, bus.command);
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b0 || bus.opcode !== 8'h02) begin
      bad++;
      $display("FAIL short_pulse_width: got recv=%b op=%h want 0 02", bus.cmd_recv_rx, bus.opcode);
    end
  endtask

  task automatic test_long();
    logic [7:0] seq[5] = '{8'h81, 8'h10, 8'h20, 8'h30, 8'h40};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      if (bus.cmd_recv_rx === 1'b1) pulses++;
      if (i < 4) begin
        repeat ($urandom_range(0, 5)) begin
          step(1'b0, 8'h00, 1'b0);
          if (bus.cmd_recv_rx === 1'b1) pulses++;
        end
      end
    end
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || pulses != 1) begin
      bad++;
      $display("FAIL long_pulse: got recv=%b pulses=%0d want 1 1", bus.cmd_recv_rx, pulses);
    end
    total++;
    if (bus.opcode !== 8'h81 || bus.command !== 32'h40302010) begin
      bad++;
      $display("FAIL long_value: got op=%h cmd=%h want 81 40302010", bus.opcode, bus.command);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (bus.cmd_dropped === 1'b1) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL timeout_early: got %0d early drops want 0", early);
    end
    step(1'b0, 8'h00, 1'b0);
    total++;
    if (bus.cmd_dropped !== 1'b1 || bus.cmd_recv_rx !== 1'b0) begin
      bad++;
      $display("FAIL timeout_drop: got drop=%b recv=%b want 1 0", bus.cmd_dropped, bus.cmd_recv_rx);
    end
    total++;
    if (bus.opcode !== 8'h81 || bus.command !== 32'h40302010) begin
      bad++;
      $display("FAIL timeout_hold: got op=%h cmd=%h want 81 40302010", bus.opcode, bus.command);
    end
    step(1'b1, 8'h01, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h01 || bus.command !== 32'h0) begin
      bad++;
      $display("FAIL timeout_resync: got recv=%b op=%h cmd=%h want 1 01 00000000",
               bus.cmd_recv_rx, bus.opcode, bus.command);
    end
  endtask

  // Each argument arrives exactly on the cycle the timer would expire.
  task automatic test_timeout_boundary();
    int drops = 0;
    step(1'b1, 8'h9A, 1'b0);
    for (int b = 0; b < 4; b++) begin
      repeat (TMO - 1) begin
        step(1'b0, 8'h00, 1'b0);
        if (bus.cmd_dropped === 1'b1) drops++;
      end
      step(1'b1, 8'(8'hE1 + b), 1'b0);
      if (bus.cmd_dropped === 1'b1) drops++;
    end
    total++;
    if (drops != 0 || bus.cmd_recv_rx !== 1'b1) begin
      bad++;
      $display("FAIL boundary_byte_wins: got drops=%0d recv=%b want 0 1", drops, bus.cmd_recv_rx);
    end
    total++;
    if (bus.opcode !== 8'h9A || bus.command !== 32'hE4E3E2E1) begin
      bad++;
      $display("FAIL boundary_value: got op=%h cmd=%h want 9a e4e3e2e1", bus.opcode, bus.command);
    end
  endtask

  task automatic test_framing();
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    total++;
    if (bus.cmd_dropped !== 1'b1 || bus.opcode !== 8'h9A) begin
      bad++;
      $display("FAIL framing_drop: got drop=%b op=%h want 1 9a", bus.cmd_dropped, bus.opcode);
    end
    step(1'b1, 8'h00, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h00 || bus.cmd_dropped !== 1'b0) begin
      bad++;
      $display("FAIL framing_resync: got recv=%b op=%h drop=%b want 1 00 0",
               bus.cmd_recv_rx, bus.opcode, bus.cmd_dropped);
    end
    // Errors while idle, with and without rx_valid, are silently discarded.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h05, 1'b1);
    total++;
    if (bus.cmd_dropped !== 1'b0 || bus.cmd_recv_rx !== 1'b0 || bus.opcode !== 8'h00) begin
      bad++;
      $display("FAIL idle_error_ignored: got drop=%b recv=%b op=%h want 0 0 00",
               bus.cmd_dropped, bus.cmd_recv_rx, bus.opcode);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq[5] = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h80 || bus.command !== 32'h04030201) begin
      bad++;
      $display("FAIL b2b_long: got recv=%b op=%h cmd=%h want 1 80 04030201",
               bus.cmd_recv_rx, bus.opcode, bus.command);
    end
    step(1'b1, 8'h05, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h05 || bus.command !== 32'h0) begin
      bad++;
      $display("FAIL b2b_short: got recv=%b op=%h cmd=%h want 1 05 00000000",
               bus.cmd_recv_rx, bus.opcode, bus.command);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    step(1'b1, 8'h81, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    ext_reset_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clock);
      #1;
      if (bus.cmd_recv_rx === 1'b1 || bus.cmd_dropped === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || bus.opcode !== 8'h00 || bus.command !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: got pulses=%0d op=%h cmd=%h want 0 00 00000000",
               pulses, bus.opcode, bus.command);
    end
    ext_reset_n = 1'b1;
    step(1'b1, 8'h02, 1'b0);
    total++;
    if (bus.cmd_recv_rx !== 1'b1 || bus.opcode !== 8'h02 || bus.command !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_short: got recv=%b op=%h cmd=%h want 1 02 00000000",
               bus.cmd_recv_rx, bus.opcode, bus.command);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int it = 0; it < 2500; it++) begin
      int r = $urandom_range(0, 99);
      int n = 1;
      logic v = 1'b0;
      logic e = 1'b0;
      logic [7:0] d = 8'($urandom);
      if (r < 55) v = 1'b1;
      else if (r < 59) begin
        e = 1'b1;
        v = 1'($urandom);
      end else if (r < 62) n = $urandom_range(TMO - 1, TMO + 1);
      for (int c = 0; c < n; c++) begin
        if (c == 0) step(v, d, e);
        else step(1'b0, 8'h00, 1'b0);
        total++;
        if (bus.opcode !== exp_op || bus.command !== exp_cmd ||
            bus.cmd_recv_rx !== exp_recv || bus.cmd_dropped !== exp_drop) begin
          bad++;
          if (errs++ < 10)
            $display("FAIL random_cycle %0d: got op=%h cmd=%h recv=%b drop=%b want %h %h %b %b",
                     it, bus.opcode, bus.command, bus.cmd_recv_rx, bus.cmd_dropped,
                     exp_op, exp_cmd, exp_recv, exp_drop);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_timeout();
    test_timeout_boundary();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
